// File: rtl/voting_ballot_collector_pkg.sv
// Shared state encoding and slot-offset helper for the ballot collector.
package voting_ballot_collector_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   // Bit offset of voter idx inside the packed ballot bus.
   function automatic int unsigned vote_slot(input int unsigned idx, input int unsigned n);
      return idx * n;
   endfunction

endpackage

// File: rtl/voting_ballot_collector.sv
// Collects one vote per distinct voter over valid/ready, drops duplicates,
// and presents the packed ballot bus with done once every voter has voted.
module voting_ballot_collector
   import voting_ballot_collector_pkg::*;
#(
   parameter int N = 2,
   parameter int M = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [M-1:0]             voter_id,
   input  logic [N-1:0]             vote,
   output logic [(2**M)*N-1:0]      ballots,
   output logic                     done,
   output logic                     dup_err,
   output logic [M:0]               count
);

   localparam int unsigned NV = 2**M;
   localparam logic [M:0]    FULL_CNT = (M+1)'(NV);
   localparam logic [M:0]    CNT_ONE  = {{M{1'b0}}, 1'b1};
   localparam logic [NV-1:0] ONEHOT_0 = {{(NV-1){1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [NV*N-1:0]    ballots_q, ballots_d;
   logic [NV-1:0]      seen_q, seen_d;
   logic [M:0]         count_q, count_d;
   logic               in_ready_q, in_ready_d;
   logic               done_q, done_d;
   logic               dup_err_q, dup_err_d;
   logic               accept_s;
   logic [NV-1:0]      voter_onehot_s;

   assign accept_s       = in_valid & in_ready_q;
   assign voter_onehot_s = ONEHOT_0 << voter_id;

   // Next-state and datapath update; start outranks a same-cycle accept.
   always_comb begin
      state_d   = state_q;
      ballots_d = ballots_q;
      seen_d    = seen_q;
      count_d   = count_q;
      dup_err_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_COLLECT;
               ballots_d = '0;
               seen_d    = '0;
               count_d   = '0;
            end else begin
               state_d = state_q;
            end
         end
         ST_COLLECT: begin
            if (start) begin
               ballots_d = '0;
               seen_d    = '0;
               count_d   = '0;
            end else if (accept_s) begin
               if ((seen_q & voter_onehot_s) != '0) begin
                  dup_err_d = 1'b1;
               end else begin
                  ballots_d[vote_slot(int'(voter_id), N) +: N] = vote;
                  seen_d  = seen_q | voter_onehot_s;
                  count_d = count_q + CNT_ONE;
                  if (count_d == FULL_CNT) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_COLLECT;
                  end
               end
            end else begin
               state_d = ST_COLLECT;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            ballots_d = '0;
            seen_d    = '0;
            count_d   = '0;
         end
      endcase
      in_ready_d = (state_d == ST_COLLECT);
      done_d     = (state_d == ST_DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ballots_q  <= '0;
         seen_q     <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b0;
         done_q     <= 1'b0;
         dup_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ballots_q  <= ballots_d;
         seen_q     <= seen_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
         done_q     <= done_d;
         dup_err_q  <= dup_err_d;
      end
   end

   assign in_ready = in_ready_q;
   assign done     = done_q;
   assign dup_err  = dup_err_q;
   assign count    = count_q;
   assign ballots  = ballots_q;

endmodule

// File: tb/tb_voting_ballot_collector.sv
// Directed bench for the ballot collector: default (N=2,M=2) and max (N=3,M=4) instances.
module tb_voting_ballot_collector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: N=2, M=2
   logic       rst_a, start_a, valid_a;
   logic [1:0] id_a, vote_a;
   logic       ready_a, done_a, dup_a;
   logic [7:0] ballots_a;
   logic [2:0] count_a;

   // Instance B: N=3, M=4
   logic        rst_b, start_b, valid_b;
   logic [3:0]  id_b;
   logic [2:0]  vote_b;
   logic        ready_b, done_b, dup_b;
   logic [47:0] ballots_b;
   logic [4:0]  count_b;
   logic [47:0] exp_b;

   int total = 0;
   int passed = 0;

   voting_ballot_collector #(.N(2), .M(2)) u_a (
      .clk(clk), .rst(rst_a), .start(start_a), .in_valid(valid_a), .in_ready(ready_a),
      .voter_id(id_a), .vote(vote_a), .ballots(ballots_a), .done(done_a),
      .dup_err(dup_a), .count(count_a)
   );

   voting_ballot_collector #(.N(3), .M(4)) u_b (
      .clk(clk), .rst(rst_b), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
      .voter_id(id_b), .vote(vote_b), .ballots(ballots_b), .done(done_b),
      .dup_err(dup_b), .count(count_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic vote_a_tick(input logic [1:0] id, input logic [1:0] v);
      valid_a = 1'b1; id_a = id; vote_a = v;
      tick();
      valid_a = 1'b0;
   endtask

   initial begin
      rst_a = 1'b1; start_a = 1'b0; valid_a = 1'b0; id_a = 2'd0; vote_a = 2'd0;
      rst_b = 1'b1; start_b = 1'b0; valid_b = 1'b0; id_b = 4'd0; vote_b = 3'd0;
      #1;
      // 1 Reset
      tick(); tick();
      check("rst_ballots", ballots_a, 64'h0);
      check("rst_count", count_a, 64'd0);
      check("rst_ready", ready_a, 64'd0);
      check("rst_done", done_a, 64'd0);
      check("rst_dup", dup_a, 64'd0);
      rst_a = 1'b0; rst_b = 1'b0;
      tick();
      check("idle_ready", ready_a, 64'd0);

      // 2 Full round
      start_a = 1'b1; tick(); start_a = 1'b0;
      check("t2_ready", ready_a, 64'd1);
      check("t2_count0", count_a, 64'd0);
      valid_a = 1'b1;
      id_a = 2'd0; vote_a = 2'd1; tick();
      check("t2_count1", count_a, 64'd1);
      id_a = 2'd1; vote_a = 2'd2; tick();
      id_a = 2'd2; vote_a = 2'd3; tick();
      check("t2_count3", count_a, 64'd3);
      check("t2_done_early", done_a, 64'd0);
      id_a = 2'd3; vote_a = 2'd0; tick();
      valid_a = 1'b0;
      check("t2_ballots", ballots_a, 64'h39);
      check("t2_count4", count_a, 64'd4);
      check("t2_done", done_a, 64'd1);
      check("t2_ready_drop", ready_a, 64'd0);

      // 3 Duplicate
      start_a = 1'b1; tick(); start_a = 1'b0;
      check("t3_cleared", ballots_a, 64'h0);
      vote_a_tick(2'd2, 2'd3);
      check("t3_count1", count_a, 64'd1);
      check("t3_nodup", dup_a, 64'd0);
      vote_a_tick(2'd2, 2'd1);
      check("t3_dup", dup_a, 64'd1);
      check("t3_slot2", ballots_a, 64'h30);
      check("t3_count_once", count_a, 64'd1);
      tick();
      check("t3_dup_pulse", dup_a, 64'd0);

      // 4 Out-of-order with gaps, in_valid held after done
      start_a = 1'b1; tick(); start_a = 1'b0;
      vote_a_tick(2'd3, 2'd2);
      tick();
      vote_a_tick(2'd1, 2'd3);
      tick(); tick();
      check("t4_partial", ballots_a, 64'h8C);
      check("t4_count2", count_a, 64'd2);
      vote_a_tick(2'd0, 2'd1);
      tick();
      vote_a_tick(2'd2, 2'd0);
      check("t4_ballots", ballots_a, 64'h8D);
      check("t4_done", done_a, 64'd1);
      valid_a = 1'b1; id_a = 2'd0; vote_a = 2'd3;
      tick(); tick(); tick();
      valid_a = 1'b0;
      check("t4_hold_ballots", ballots_a, 64'h8D);
      check("t4_hold_count", count_a, 64'd4);
      check("t4_hold_done", done_a, 64'd1);
      check("t4_hold_dup", dup_a, 64'd0);

      // 5 Restart with a same-cycle vote
      start_a = 1'b1; tick(); start_a = 1'b0;
      check("t5_restart_count", count_a, 64'd0);
      check("t5_restart_done", done_a, 64'd0);
      vote_a_tick(2'd0, 2'd2);
      vote_a_tick(2'd1, 2'd1);
      check("t5_partial", ballots_a, 64'h06);
      start_a = 1'b1; valid_a = 1'b1; id_a = 2'd2; vote_a = 2'd3;
      tick();
      start_a = 1'b0; valid_a = 1'b0;
      check("t5_lost_count", count_a, 64'd0);
      check("t5_lost_ballots", ballots_a, 64'h0);
      check("t5_ready", ready_a, 64'd1);
      vote_a_tick(2'd0, 2'd3);
      vote_a_tick(2'd1, 2'd0);
      vote_a_tick(2'd2, 2'd1);
      vote_a_tick(2'd3, 2'd2);
      check("t5_ballots", ballots_a, 64'h93);
      check("t5_done", done_a, 64'd1);

      // 6 Reset mid-round, rst outranks start
      start_a = 1'b1; tick(); start_a = 1'b0;
      vote_a_tick(2'd0, 2'd1);
      vote_a_tick(2'd1, 2'd1);
      vote_a_tick(2'd2, 2'd1);
      check("t6_count3", count_a, 64'd3);
      rst_a = 1'b1; start_a = 1'b1; tick();
      rst_a = 1'b0; start_a = 1'b0;
      check("t6_ballots", ballots_a, 64'h0);
      check("t6_count", count_a, 64'd0);
      check("t6_ready", ready_a, 64'd0);
      check("t6_done", done_a, 64'd0);
      tick();
      check("t6_stay_idle", ready_a, 64'd0);

      // 6b Max parameters: 16 voters, 3-bit votes
      exp_b = '0;
      start_b = 1'b1; tick(); start_b = 1'b0;
      check("mx_ready", ready_b, 64'd1);
      for (int i = 0; i < 16; i++) begin
         valid_b = 1'b1; id_b = 4'(i); vote_b = 3'((i * 5 + 1) % 8);
         exp_b[i*3 +: 3] = 3'((i * 5 + 1) % 8);
         tick();
         if (i == 14) begin
            check("mx_count15", count_b, 64'd15);
            check("mx_not_done", done_b, 64'd0);
         end
      end
      valid_b = 1'b0;
      check("mx_ballots", ballots_b, {16'h0, exp_b});
      check("mx_count16", count_b, 64'd16);
      check("mx_done", done_b, 64'd1);
      check("mx_ready_drop", ready_b, 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
